// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   trial_c;
  logic             qbit_c;
  logic [WIDTH-1:0] prem_next_c;
  logic [WIDTH-1:0] shift_next_c;
  logic [WIDTH-1:0] quot_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  // Magnitudes feed the unsigned core; signs are re-applied on result load.
  always_comb begin
    a_mag_c    = dividend[WIDTH-1] ? ((~dividend) + WIDTH'(1)) : dividend;
    b_mag_c    = divisor[WIDTH-1]  ? ((~divisor) + WIDTH'(1))  : divisor;
    quot_fix_c = neg_quot_q ? ((~shift_next_c) + WIDTH'(1)) : shift_next_c;
    rem_fix_c  = neg_rem_q  ? ((~prem_next_c) + WIDTH'(1))  : prem_next_c;
  end
`else
  always_comb begin
    a_mag_c    = dividend;
    b_mag_c    = divisor;
    quot_fix_c = shift_next_c;
    rem_fix_c  = prem_next_c;
  end
`endif

  // Single trial subtraction; the extra bit makes the borrow unambiguous.
  always_comb begin
    shifted_c    = {prem_q, shift_q[WIDTH-1]};
    trial_c      = shifted_c - {1'b0, dvsr_q};
    qbit_c       = ~trial_c[WIDTH];
    prem_next_c  = qbit_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
    shift_next_c = {shift_q[WIDTH-2:0], qbit_c};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      S_CALC: begin
        busy_d  = 1'b1;
        prem_d  = prem_next_c;
        shift_d = shift_next_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = quot_fix_c;
          rem_d   = rem_fix_c;
        end
      end
      default: begin
        // IDLE and FIN both accept a new operation.
        state_d = S_IDLE;
        if (start) begin
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
            prem_d  = '0;
            shift_d = a_mag_c;
            dvsr_d  = b_mag_c;
            cnt_d   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prem_q  <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, scoreboard queue and handshake corner cases.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  seq_divider #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_q = 8'h00;
  logic [7:0] last_r = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request at the current negedge; the next posedge is the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] qe,
                        input logic [7:0] re, input logic de);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = qe; e.r = re; e.dbz = de;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Wait (bounded) for done, then check latency, busy profile and the scoreboard head.
  task automatic wait_done(input string name, input int edges0, input int exp_lat);
    int   edges;
    int   busy_cyc;
    exp_t e;
    edges    = edges0;
    busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    if (!done) begin
      check({name, " timeout"}, 32'(done), 32'd1);
      return;
    end
    check({name, " latency"}, 32'(edges), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - edges0));
    check({name, " busy_at_done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      check({name, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, " quotient"}, 32'(quotient), 32'(e.q));
    check({name, " remainder"}, 32'(remainder), 32'(e.r));
    check({name, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
    last_q = e.q;
    last_r = e.r;
  endtask

  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dbz);
    int sa;
    int sbv;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; dbz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa  = int'($signed(a));
      sbv = int'($signed(b));
`else
      sa  = int'(a);
      sbv = int'(b);
`endif
      q = 8'(sa / sbv);
      r = 8'(sa % sbv);
      dbz = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    vec_t       v;
    int         dc;
    logic [7:0] a, b, q, r;
    logic       d;

    vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 9});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9});
    vecs.push_back('{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 9});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9});
    vecs.push_back('{8'h2A,  8'd0,   8'hFF,  8'h2A, 1'b1, 1});
    vecs.push_back('{8'd10,  8'd2,   8'd5,   8'd0,  1'b0, 9});
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{8'h9C,  8'h07,  8'hF2,  8'hFE, 1'b0, 9});
    vecs.push_back('{8'h64,  8'hF9,  8'hF2,  8'h02, 1'b0, 9});
    vecs.push_back('{8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, 9});
    vecs.push_back('{8'h9C,  8'h00,  8'hFF,  8'h9C, 1'b1, 1});
`endif

    rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'h00);
    check("reset remainder", 32'(remainder), 32'h00);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    dc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    check("idle no_activity", 32'(dc), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      launch(v.a, v.b, v.q, v.r, v.dbz);
      wait_done($sformatf("vec%0d_%0d/%0d", i, v.a, v.b), 1, v.lat);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse_width", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = (i % 8 == 7) ? 8'h00 : 8'($urandom);
      model(a, b, q, r, d);
      launch(a, b, q, r, d);
      wait_done($sformatf("rand%0d_%0h/%0h", i, a, b), 1, d ? 1 : 9);
      @(negedge clk);
    end

    // start mid-CALC is ignored; results and outputs stay untouched until done.
    launch(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (2) @(negedge clk);
    check("midcalc quotient_held", 32'(quotient), 32'(last_q));
    check("midcalc remainder_held", 32'(remainder), 32'(last_r));
    start = 1'b1; dividend = 8'd99; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("midcalc_start", 4, 9);
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("midcalc no_second_done", 32'(dc), 32'd0);

    // start during FIN launches the next operation immediately.
    launch(8'd100, 8'd9, 8'd11, 8'd1, 1'b0);
    wait_done("b2b_first", 1, 9);
    launch(8'd250, 8'd16, 8'd15, 8'd10, 1'b0);
    wait_done("b2b_second", 1, 9);
    @(negedge clk);

    // Asynchronous reset mid-operation discards it without a done pulse.
    launch(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst quotient", 32'(quotient), 32'h00);
    check("async_rst remainder", 32'(remainder), 32'h00);
    check("async_rst div_by_zero", 32'(div_by_zero), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    check("after_rst no_done", 32'(dc), 32'd0);

    launch(8'd10, 8'd2, 8'd5, 8'd0, 1'b0);
    wait_done("after_rst_op", 1, 9);
    @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
